// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one combinational ALU between two requesters,
// with registered responses and a private carry register per requester.
module alu_share_ctrl #(
    parameter int DATA_W = 8,
    parameter int OP_W   = 3,
    parameter int FLAG_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_valid,
    output logic              r0_ready,
    input  logic [OP_W-1:0]   r0_opcode,
    input  logic [DATA_W-1:0] r0_a,
    input  logic [DATA_W-1:0] r0_b,
    output logic              r0_rsp_valid,
    input  logic              r0_rsp_ready,
    output logic [DATA_W-1:0] r0_rsp_result,
    output logic [FLAG_W-1:0] r0_rsp_flags,
    input  logic              r1_valid,
    output logic              r1_ready,
    input  logic [OP_W-1:0]   r1_opcode,
    input  logic [DATA_W-1:0] r1_a,
    input  logic [DATA_W-1:0] r1_b,
    output logic              r1_rsp_valid,
    input  logic              r1_rsp_ready,
    output logic [DATA_W-1:0] r1_rsp_result,
    output logic [FLAG_W-1:0] r1_rsp_flags,
    output logic [DATA_W-1:0] alu_data1,
    output logic [DATA_W-1:0] alu_data2,
    output logic [OP_W-1:0]   alu_opcode,
    output logic              alu_carry_in,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_carry_out,
    input  logic              alu_zero,
    input  logic              alu_sign,
    input  logic              alu_parity,
    input  logic              alu_aux,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t              state;
    logic                last_grant;
    logic                owner;
    logic [1:0]          carry;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_result;
    logic [FLAG_W-1:0]   rsp_flags;
    logic                grant;
    logic                take;
    logic                rsp_done;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        grant    = (r0_valid & r1_valid) ? ~last_grant : r1_valid;
        take     = (state == IDLE) & (grant ? r1_valid : r0_valid);
        rsp_done = owner ? r1_rsp_ready : r0_rsp_ready;
    end

    assign r0_ready      = (state == IDLE) & ~grant;
    assign r1_ready      = (state == IDLE) & grant;
    assign r0_rsp_valid  = rsp_valid[0];
    assign r1_rsp_valid  = rsp_valid[1];
    assign r0_rsp_result = rsp_result;
    assign r1_rsp_result = rsp_result;
    assign r0_rsp_flags  = rsp_flags;
    assign r1_rsp_flags  = rsp_flags;

    // The ALU lines double as the latched request; they are nonzero only during EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            last_grant   <= 1'b1;
            owner        <= 1'b0;
            carry        <= '0;
            rsp_valid    <= '0;
            rsp_result   <= '0;
            rsp_flags    <= '0;
            alu_data1    <= '0;
            alu_data2    <= '0;
            alu_opcode   <= '0;
            alu_carry_in <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                IDLE: if (take) begin
                    owner        <= grant;
                    last_grant   <= grant;
                    alu_data1    <= grant ? r1_a : r0_a;
                    alu_data2    <= grant ? r1_b : r0_b;
                    alu_opcode   <= grant ? r1_opcode : r0_opcode;
                    alu_carry_in <= carry[grant];
                    busy         <= 1'b1;
                    state        <= EXEC;
                end
                EXEC: begin
                    rsp_result       <= alu_result;
                    rsp_flags        <= {alu_aux, alu_parity, alu_sign, alu_zero, alu_carry_out};
                    rsp_valid[owner] <= 1'b1;
                    if (alu_opcode <= OP_W'(2))
                        carry[owner] <= alu_carry_out;
                    alu_data1        <= '0;
                    alu_data2        <= '0;
                    alu_opcode       <= '0;
                    alu_carry_in     <= 1'b0;
                    state            <= RESP;
                end
                RESP: if (rsp_done) begin
                    rsp_valid <= '0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of alu_share_ctrl against a behavioural 8-bit ALU.
module tb_alu_share_ctrl;
    logic       clk = 0;
    logic       rst;
    logic       r0_valid, r0_ready, r0_rsp_valid, r0_rsp_ready;
    logic [2:0] r0_opcode;
    logic [7:0] r0_a, r0_b, r0_rsp_result;
    logic [4:0] r0_rsp_flags;
    logic       r1_valid, r1_ready, r1_rsp_valid, r1_rsp_ready;
    logic [2:0] r1_opcode;
    logic [7:0] r1_a, r1_b, r1_rsp_result;
    logic [4:0] r1_rsp_flags;
    logic [7:0] alu_data1, alu_data2, alu_result;
    logic [2:0] alu_opcode;
    logic       alu_carry_in, alu_carry_out, alu_zero, alu_sign, alu_parity, alu_aux;
    logic       busy;
    logic [8:0] s;
    logic [4:0] h;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    alu_share_ctrl dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_a(r0_a), .r0_b(r0_b),
        .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
        .r0_rsp_result(r0_rsp_result), .r0_rsp_flags(r0_rsp_flags),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_a(r1_a), .r1_b(r1_b),
        .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
        .r1_rsp_result(r1_rsp_result), .r1_rsp_flags(r1_rsp_flags),
        .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_opcode(alu_opcode),
        .alu_carry_in(alu_carry_in), .alu_result(alu_result), .alu_carry_out(alu_carry_out),
        .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_parity(alu_parity), .alu_aux(alu_aux),
        .busy(busy)
    );

    // 000 adc, 001 add, 010 sub, 011 and, 100 or, 101 xor, 110 not, 111 shl
    always_comb begin
        s             = '0;
        h             = '0;
        alu_result    = '0;
        alu_carry_out = 1'b0;
        alu_aux       = 1'b0;
        case (alu_opcode)
            3'd0: begin
                s = {1'b0, alu_data1} + {1'b0, alu_data2} + 9'(alu_carry_in);
                h = {1'b0, alu_data1[3:0]} + {1'b0, alu_data2[3:0]} + 5'(alu_carry_in);
            end
            3'd1: begin
                s = {1'b0, alu_data1} + {1'b0, alu_data2};
                h = {1'b0, alu_data1[3:0]} + {1'b0, alu_data2[3:0]};
            end
            3'd2: begin
                s = {1'b0, alu_data1} - {1'b0, alu_data2};
                h = {1'b0, alu_data1[3:0]} - {1'b0, alu_data2[3:0]};
            end
            3'd3: s = {1'b0, alu_data1 & alu_data2};
            3'd4: s = {1'b0, alu_data1 | alu_data2};
            3'd5: s = {1'b0, alu_data1 ^ alu_data2};
            3'd6: s = {1'b0, ~alu_data1};
            default: s = {1'b0, alu_data1[6:0], 1'b0};
        endcase
        alu_result    = s[7:0];
        alu_carry_out = (alu_opcode <= 3'd2) ? s[8] : 1'b0;
        alu_aux       = (alu_opcode <= 3'd2) ? h[4] : 1'b0;
    end
    assign alu_zero   = (alu_result == 8'h00);
    assign alu_sign   = alu_result[7];
    assign alu_parity = ~^alu_result;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic rsp_chk(input logic who, input logic [7:0] res, input logic [4:0] fl, input string tag);
        chk({tag, "_valid"}, 32'(who ? r1_rsp_valid : r0_rsp_valid), 1);
        chk({tag, "_other"}, 32'(who ? r0_rsp_valid : r1_rsp_valid), 0);
        chk({tag, "_result"}, 32'(who ? r1_rsp_result : r0_rsp_result), 32'(res));
        chk({tag, "_flags"}, 32'(who ? r1_rsp_flags : r0_rsp_flags), 32'(fl));
        chk({tag, "_alu_idle"}, 32'({alu_opcode, alu_data1, alu_data2, alu_carry_in}), 0);
    endtask

    // One full operation from a single requester with rsp_ready already high.
    task automatic op(input logic who, input logic [2:0] opc, input logic [7:0] a, input logic [7:0] b,
                      input logic cin, input logic [7:0] res, input logic [4:0] fl, input string tag);
        logic rdy;
        @(posedge clk); #1;
        if (who) begin r1_valid = 1; r1_opcode = opc; r1_a = a; r1_b = b; end
        else     begin r0_valid = 1; r0_opcode = opc; r0_a = a; r0_b = b; end
        @(negedge clk);
        rdy = who ? r1_ready : r0_ready;
        for (int k = 0; k < 8 && !rdy; k++) begin
            @(negedge clk);
            rdy = who ? r1_ready : r0_ready;
        end
        chk({tag, "_hs"}, 32'(rdy), 1);
        @(posedge clk); #1;
        if (who) begin r1_valid = 0; r1_a = ~a; r1_opcode = ~opc; end
        else     begin r0_valid = 0; r0_a = ~a; r0_opcode = ~opc; end
        @(negedge clk);
        chk({tag, "_exec_cin"}, 32'(alu_carry_in), 32'(cin));
        chk({tag, "_exec_a"}, 32'(alu_data1), 32'(a));
        chk({tag, "_exec_op"}, 32'(alu_opcode), 32'(opc));
        chk({tag, "_exec_busy"}, 32'({busy, r0_ready, r1_ready, r0_rsp_valid, r1_rsp_valid}), 32'b10000);
        @(posedge clk); #1;
        @(negedge clk);
        rsp_chk(who, res, fl, tag);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1;
        r0_valid = 0; r0_opcode = 0; r0_a = 0; r0_b = 0; r0_rsp_ready = 1;
        r1_valid = 0; r1_opcode = 0; r1_a = 0; r1_b = 0; r1_rsp_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rsp_valid", 32'({r0_rsp_valid, r1_rsp_valid}), 0);
        chk("rst_result", 32'(r0_rsp_result), 0);
        chk("rst_flags", 32'(r0_rsp_flags), 0);
        chk("rst_alu", 32'({alu_opcode, alu_data1, alu_data2, alu_carry_in}), 0);
        // Tie from reset: r0 first, then strict alternation.
        @(posedge clk); #1;
        rst = 0;
        r0_valid = 1; r0_opcode = 3'd1; r0_a = 8'h12; r0_b = 8'h34;
        r1_valid = 1; r1_opcode = 3'd1; r1_a = 8'h05; r1_b = 8'h03;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("tie_r0_ready", 32'(r0_ready), 32'(i % 2 == 0));
            chk("tie_r1_ready", 32'(r1_ready), 32'(i % 2 == 1));
            @(posedge clk); #1;
            @(posedge clk); #1;
            @(negedge clk);
            rsp_chk(1'(i % 2), (i % 2 == 1) ? 8'h08 : 8'h46, 5'b00000, "tie");
            @(posedge clk); #1;
        end
        r0_valid = 0; r1_valid = 0;
        op(0, 3'd1, 8'h12, 8'h34, 0, 8'h46, 5'b00000, "single");
        // Backpressure: response held five cycles while r1 waits.
        r0_rsp_ready = 0;
        r0_valid = 1; r0_opcode = 3'd1; r0_a = 8'h80; r0_b = 8'h80;
        @(negedge clk);
        chk("bp_hs", 32'(r0_ready), 1);
        @(posedge clk); #1;
        r0_valid = 0;
        r1_valid = 1; r1_opcode = 3'd1; r1_a = 8'h01; r1_b = 8'h01;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_valid", 32'({r0_rsp_valid, r1_rsp_valid}), 32'b10);
            chk("bp_hold", 32'({r0_rsp_result, r0_rsp_flags}), 32'({8'h00, 5'b01011}));
            chk("bp_ready_busy", 32'({r0_ready, r1_ready, busy}), 32'b001);
            @(posedge clk); #1;
        end
        r0_rsp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_release", 32'({busy, r0_rsp_valid, r1_ready}), 32'b001);
        @(posedge clk); #1;
        r1_valid = 0;
        @(posedge clk); #1;
        @(negedge clk);
        rsp_chk(1, 8'h02, 5'b00000, "bp_r1");
        @(posedge clk); #1;
        // Carry isolation between requesters.
        op(0, 3'd1, 8'hFF, 8'h01, 1, 8'h00, 5'b11011, "ci_r0_add");
        op(1, 3'd0, 8'h01, 8'h01, 0, 8'h02, 5'b00000, "ci_r1_adc");
        op(0, 3'd0, 8'h10, 8'h20, 1, 8'h31, 5'b00000, "ci_r0_adc");
        // Logical op must not touch the owner's carry.
        op(0, 3'd1, 8'hFF, 8'h01, 0, 8'h00, 5'b11011, "na_set");
        op(0, 3'd3, 8'hF0, 8'h0F, 1, 8'h00, 5'b01010, "na_and");
        op(0, 3'd0, 8'h00, 8'h00, 1, 8'h01, 5'b00000, "na_adc");
        // Reset during EXEC with both carry registers set.
        op(1, 3'd1, 8'hFF, 8'h01, 0, 8'h00, 5'b11011, "rm_r1_set");
        op(0, 3'd1, 8'hFF, 8'h01, 0, 8'h00, 5'b11011, "rm_r0_set");
        r1_valid = 1; r1_opcode = 3'd0; r1_a = 8'h01; r1_b = 8'h01;
        @(negedge clk);
        chk("rm_hs", 32'(r1_ready), 1);
        @(posedge clk); #1;
        r1_valid = 0;
        rst = 1;
        @(negedge clk);
        chk("rm_in_exec", 32'(busy), 1);
        @(posedge clk); #1;
        rst = 0;
        r0_valid = 1; r0_opcode = 3'd0; r0_a = 8'h01; r0_b = 8'h01;
        r1_valid = 1; r1_opcode = 3'd0; r1_a = 8'h01; r1_b = 8'h01;
        @(negedge clk);
        chk("rm_busy", 32'(busy), 0);
        chk("rm_rsp", 32'({r0_rsp_valid, r1_rsp_valid, r0_rsp_result, r0_rsp_flags}), 0);
        chk("rm_tie", 32'({r0_ready, r1_ready}), 32'b10);
        @(posedge clk); #1;
        r0_valid = 0;
        @(negedge clk);
        chk("rm_r0_cin", 32'(alu_carry_in), 0);
        @(posedge clk); #1;
        @(negedge clk);
        rsp_chk(0, 8'h02, 5'b00000, "rm_r0");
        @(posedge clk); #1;
        @(negedge clk);
        chk("rm_r1_ready", 32'(r1_ready), 1);
        @(posedge clk); #1;
        r1_valid = 0;
        @(negedge clk);
        chk("rm_r1_cin", 32'(alu_carry_in), 0);
        @(posedge clk); #1;
        @(negedge clk);
        rsp_chk(1, 8'h02, 5'b00000, "rm_r1");
        @(posedge clk); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
